// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: program counter, instruction-memory address,
// and the IF/ID pipeline register with stall, flush and redirect handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fetch_pc_plus4;
    logic [31:0] instr_q, instr_n;
    logic [31:0] pc_id_q, pc_id_n;
    logic [31:0] pc_plus4_q, pc_plus4_n;
    logic        valid_q, valid_n;
    logic [31:0] count_q, count_d;

    assign fetch_pc_plus4 = fetch_pc_q + 32'd4;

    // Redirect wins over stall for the PC.
    always_comb begin
        fetch_pc_d = fetch_pc_plus4;
        if (pc_src_e) begin
            fetch_pc_d = {pc_target_e[31:2], 2'b00};
        end else if (stall_f) begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // A redirect squashes the wrong-path word being fetched this cycle.
    always_comb begin
        instr_n    = instr_q;
        pc_id_n    = pc_id_q;
        pc_plus4_n = pc_plus4_q;
        valid_n    = valid_q;
        count_d    = count_q;
        if (flush_d || pc_src_e) begin
            instr_n    = NOP_INSTR;
            pc_id_n    = 32'h0;
            pc_plus4_n = 32'h0;
            valid_n    = 1'b0;
        end else if (!stall_f) begin
            instr_n    = imem_rdata;
            pc_id_n    = fetch_pc_q;
            pc_plus4_n = fetch_pc_plus4;
            valid_n    = 1'b1;
            count_d    = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= ResetPcAligned;
            instr_q    <= NOP_INSTR;
            pc_id_q    <= 32'h0;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
            count_q    <= 32'h0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_n;
            pc_id_q    <= pc_id_n;
            pc_plus4_q <= pc_plus4_n;
            valid_q    <= valid_n;
            count_q    <= count_d;
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign instr_d     = instr_q;
    assign pc_d        = pc_id_q;
    assign pc_plus4_d  = pc_plus4_q;
    assign valid_d     = valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free-run, stall, redirect, flush, PC wrap, async reset.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pc_plus4_d, fetch_count;
    logic        valid_d;

    logic [31:0] imem_addr2, imem_rdata2, instr_d2, pc_d2, pc_plus4_d2, fetch_count2;
    logic        valid_d2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Program words at 0x0/0x4/0x8; every other address returns addr ^ 0xDEAD_0000.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            32'h8:   return 32'h0020_81B3;
            default: return a ^ 32'hDEAD_0000;
        endcase
    endfunction

    assign imem_rdata  = imem(imem_addr);
    assign imem_rdata2 = imem(imem_addr2);

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .flush_d(flush_d), .pc_src_e(pc_src_e),
        .pc_target_e(pc_target_e), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .stall_f(1'b0), .flush_d(1'b0), .pc_src_e(1'b0),
        .pc_target_e(32'h0), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .instr_d(instr_d2), .pc_d(pc_d2), .pc_plus4_d(pc_plus4_d2), .valid_d(valid_d2),
        .fetch_count(fetch_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_f = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0; pc_target_e = 32'h0;
        #1;
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_instr", instr_d, 32'h0000_0013);
        check("rst_pc_d", pc_d, 32'h0);
        check("rst_valid", {31'b0, valid_d}, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_wrap_addr", imem_addr2, 32'hFFFF_FFF8);
        edge_step();
        check("rst_hold_addr", imem_addr, 32'h0);
        rst = 1'b0;

        edge_step();  // edge 1
        check("e1_instr", instr_d, 32'h0050_0093);
        check("e1_pc", pc_d, 32'h0);
        check("e1_valid", {31'b0, valid_d}, 32'h1);
        check("e1_count", fetch_count, 32'd1);
        check("e1_addr", imem_addr, 32'h4);
        check("w1_pc", pc_d2, 32'hFFFF_FFF8);
        check("w1_pc4", pc_plus4_d2, 32'hFFFF_FFFC);

        edge_step();  // edge 2
        check("e2_instr", instr_d, 32'h00A0_0113);
        check("e2_pc", pc_d, 32'h4);
        check("e2_count", fetch_count, 32'd2);
        check("w2_pc", pc_d2, 32'hFFFF_FFFC);
        check("w2_pc4", pc_plus4_d2, 32'h0);

        stall_f = 1'b1;
        edge_step();  // edge 3, stalled
        check("s1_pc", pc_d, 32'h4);
        check("s1_instr", instr_d, 32'h00A0_0113);
        check("s1_addr", imem_addr, 32'h8);
        check("s1_count", fetch_count, 32'd2);
        check("w3_pc", pc_d2, 32'h0);
        check("w3_instr", instr_d2, 32'h0050_0093);
        edge_step();  // edge 4, stalled
        check("s2_pc", pc_d, 32'h4);
        check("s2_addr", imem_addr, 32'h8);
        check("s2_count", fetch_count, 32'd2);
        stall_f = 1'b0;

        edge_step();  // edge 5
        check("e5_pc", pc_d, 32'h8);
        check("e5_instr", instr_d, 32'h0020_81B3);
        check("e5_count", fetch_count, 32'd3);
        edge_step();  // edge 6
        check("e6_pc", pc_d, 32'hC);
        check("e6_addr", imem_addr, 32'h10);
        check("e6_count", fetch_count, 32'd4);

        pc_src_e = 1'b1; pc_target_e = 32'h0000_0103;
        edge_step();  // edge 7, redirect
        check("r_addr", imem_addr, 32'h100);
        check("r_valid", {31'b0, valid_d}, 32'h0);
        check("r_instr", instr_d, 32'h0000_0013);
        check("r_pc", pc_d, 32'h0);
        check("r_count", fetch_count, 32'd4);
        pc_src_e = 1'b0; pc_target_e = 32'h0;
        edge_step();  // edge 8
        check("r2_pc", pc_d, 32'h100);
        check("r2_valid", {31'b0, valid_d}, 32'h1);
        check("r2_instr", instr_d, 32'hDEAD_0100);
        check("r2_pc4", pc_plus4_d, 32'h104);
        check("r2_count", fetch_count, 32'd5);

        stall_f = 1'b1; pc_src_e = 1'b1; pc_target_e = 32'h40;
        edge_step();  // edge 9
        check("sr_addr", imem_addr, 32'h40);
        check("sr_valid", {31'b0, valid_d}, 32'h0);
        check("sr_count", fetch_count, 32'd5);
        stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = 32'h0;
        edge_step();  // edge 10
        check("sr2_pc", pc_d, 32'h40);
        check("sr2_count", fetch_count, 32'd6);

        stall_f = 1'b1; flush_d = 1'b1;
        edge_step();  // edge 11
        check("sf_addr", imem_addr, 32'h44);
        check("sf_valid", {31'b0, valid_d}, 32'h0);
        check("sf_instr", instr_d, 32'h0000_0013);
        check("sf_count", fetch_count, 32'd6);
        stall_f = 1'b0; flush_d = 1'b0;
        edge_step();  // edge 12
        check("sf2_pc", pc_d, 32'h44);
        check("sf2_count", fetch_count, 32'd7);

        // Async reset mid-cycle while a redirect is pending.
        pc_src_e = 1'b1; pc_target_e = 32'h200;
        #2 rst = 1'b1;
        #1;
        check("ar_addr", imem_addr, 32'h0);
        check("ar_valid", {31'b0, valid_d}, 32'h0);
        check("ar_count", fetch_count, 32'h0);
        check("ar_instr", instr_d, 32'h0000_0013);
        pc_src_e = 1'b0; pc_target_e = 32'h0;
        edge_step();
        rst = 1'b0;
        edge_step();
        check("ar2_pc", pc_d, 32'h0);
        check("ar2_addr", imem_addr, 32'h4);
        check("ar2_count", fetch_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I pipeline. Holds the program counter, drives the word address into the instruction memory, captures the returned instruction into the IF/ID pipeline register, and handles stalls, flushes and branch/jump redirects from the execute stage. It sits directly upstream of the instruction memory and feeds the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction injected into IF/ID on reset/flush (addi x0,x0,0)

- clk  in  1  pipeline clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- stall_f  in  1  hold PC and IF/ID (load-use hazard)
- flush_d  in  1  replace IF/ID contents with bubble
- pc_src_e  in  1  redirect request from execute (taken branch / jal / jalr)
- pc_target_e  in  32  redirect target address
- imem_addr  out  32  byte address to instruction memory (= PC)
- imem_rdata  in  32  instruction word from memory, combinational read of imem_addr
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC of instr_d
- pc_plus4_d  out  32  IF/ID pc_d + 4
- valid_d  out  1  IF/ID holds a real fetched instruction (0 = bubble)
- fetch_count  out  32  number of instructions loaded into IF/ID with valid_d=1

## Operation
- PC register, PC[1:0] always 00; pc_target_e[1:0] ignored (forced to 00).
- imem_addr = PC, purely combinational from the register; no other logic on that path.
- Next-PC priority (highest first): pc_src_e -> {pc_target_e[31:2],2'b00}; stall_f -> hold; else PC+4.
- pc_src_e overrides stall_f for the PC.
- PC+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- IF/ID priority (highest first): flush_d or pc_src_e -> instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0; stall_f -> hold all four; else load instr_d=imem_rdata, pc_d=PC, pc_plus4_d=PC+4, valid_d=1.
- A redirect always squashes the wrong-path instruction currently being fetched; no external flush_d is required for it.
- fetch_count increments by 1 on every edge where IF/ID loads with valid_d=1. It does not change on stall, flush or redirect, and wraps at 2^32.
- Reset (rst=1, asynchronous):
  - PC=RESET_PC, so imem_addr=RESET_PC immediately.
  - instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, fetch_count=0.
- Reset asserted mid-operation discards any pending redirect or stall immediately.
- After rst deasserts, the first rising edge loads IF/ID from RESET_PC and advances PC to RESET_PC+4.

## Timing
- Fetch latency is 1 cycle: PC value in cycle n appears as pc_d/instr_d after edge n+1.
- imem_rdata is sampled at the same edge that advances PC. The memory must settle within the cycle.
- Redirect: pc_src_e=1 in cycle n.
  - Edge n+1: PC=target, IF/ID=bubble.
  - Edge n+2: instr_d = instruction at target, valid_d=1.
  - Penalty: 1 bubble from fetch, plus whatever the hazard unit flushes downstream.
- Stall: stall_f held k cycles freezes PC and IF/ID for exactly k edges, and fetch_count is unchanged.
- A stall does not re-fetch a different word, because imem_addr is stable while PC is held.
- Simultaneous stall_f and flush_d: PC holds, IF/ID becomes a bubble.
- Simultaneous pc_src_e and stall_f: PC redirects, IF/ID becomes a bubble.
- rst is asynchronous on assertion. Deassertion is assumed synchronous to clk, synchronized externally.

## Test plan
- Reset then free-run with memory words 0x00500093, 0x00A00113, 0x002081B3 at 0x0, 0x4, 0x8:
  - instr_d sequence after edges 1..3 matches that order.
  - pc_d = 0, 4, 8; valid_d=1.
  - fetch_count = 3.
- stall_f=1 for 2 cycles while pc_d=0x4: pc_d, instr_d and imem_addr=0x8 hold for 2 edges; fetch_count frozen; resumes with pc_d=0x8.
- pc_src_e=1, pc_target_e=0x0000_0103 while PC=0x10:
  - Next edge: PC=0x100, valid_d=0, instr_d=0x00000013.
  - Following edge: pc_d=0x100, valid_d=1.
- Simultaneous stall_f=1 and pc_src_e=1 (target 0x40): PC=0x40, IF/ID bubble. Also stall_f=1 with flush_d=1: PC held, bubble inserted.
- RESET_PC=32'hFFFF_FFF8, free-run: pc_d = 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, and pc_plus4_d of 0xFFFF_FFFC is 0x0.
- Assert rst asynchronously mid-cycle during a redirect: imem_addr=RESET_PC and valid_d=0 before the next edge, fetch_count=0, and the redirect is not applied after release.
